glyph_serializer: RTL and testbench
===================================

GLYPH_SERIALIZER -- requirements
Module: glyph_serializer

Interface
REQ-001 Parameter: GAP_BITS, default 1, number of blank columns appended after the 5 glyph pixels (range 0..3).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  character request present.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_code  input  8  character code, 0..255.
REQ-007 req_row  input  3  scan line within glyph, 0..6 valid.
REQ-008 rom_ad  output  11  glyph ROM address.
REQ-009 rom_ce  output  1  glyph ROM read enable.
REQ-010 rom_dout  input  5  ROM scan-line data, valid the cycle after the rom_ce edge (1-cycle registered latency).
REQ-011 pix  output  1  current pixel, 1 = foreground.
REQ-012 pix_valid  output  1  pix holds a valid pixel.
REQ-013 pix_ready  input  1  consumer takes pix this cycle.
REQ-014 req_inv  input  1  reverse-video attribute (present only with GLYPH_INVERT_EN).

Function
REQ-015 The block SHALL use FSM states IDLE, FETCH, LOAD, SHIFT.
REQ-016 A request transfers when req_valid && req_ready; code, row (and inv) SHALL be latched on that edge.
REQ-017 req_ready SHALL be 1 in IDLE, and in SHIFT only on the cycle the last pixel transfers; 0 otherwise.
REQ-018 After the transfer: row <= 6 -> FETCH; row 7 -> SHIFT with shift register loaded with zeros, and no ROM access.
REQ-019 In FETCH, rom_ce SHALL be 1 for exactly one cycle with rom_ad = code*7 + row (11-bit, max 1791); next state LOAD.
REQ-020 rom_ce SHALL be 0 in all other states; rom_ad SHALL hold its last value when rom_ce = 0.
REQ-021 In LOAD, rom_dout SHALL be captured into a (5+GAP_BITS)-bit shift register, with glyph bits in the upper positions and zeros in the GAP_BITS lower positions; next state SHIFT.
REQ-022 In SHIFT, pix_valid = 1 and pix = shift-register MSB (rom_dout bit 4 first, leftmost).
REQ-023 On pix_valid && pix_ready, the register SHALL shift left by one; pix and pix_valid SHALL be held stable while pix_ready = 0.
REQ-024 After 5+GAP_BITS transfers: if a request transfers on the same edge -> FETCH (or SHIFT for row 7); else -> IDLE.
REQ-025 Latency: request edge N -> rom_ce in cycle N+1 -> pix_valid first asserted in cycle N+3.
REQ-026 pix_valid SHALL be 0 in IDLE, FETCH and LOAD.
REQ-027 Back-to-back requests SHALL incur exactly 2 idle pixel cycles (FETCH and LOAD) between glyphs.

Reset
REQ-028 resetn = 0 SHALL immediately force: state IDLE, req_ready 1, rom_ce 0, rom_ad 0, pix 0, pix_valid 0, shift register 0, latched fields 0.
REQ-029 Reset asserted mid-glyph SHALL discard the in-flight glyph; after release, no remaining pixels SHALL appear.

Configuration
REQ-030 With macro GLYPH_INVERT_EN defined, req_inv SHALL exist and be latched with the request; when latched inv = 1, every output pixel (glyph and gap) SHALL be inverted.
REQ-031 Without GLYPH_INVERT_EN, the req_inv port SHALL be absent and pixels SHALL be output uninverted.

Verification
REQ-032 code 0x41, row 2, GAP_BITS 1, rom_dout 5'b10101 -> one rom_ce with rom_ad 457; pix sequence 1,0,1,0,1,0; then IDLE.
REQ-033 row 7, code 0xFF -> rom_ce never asserted; 6 pixels, all 0.
REQ-034 pix_ready held 0 for 4 cycles after the first pixel -> pix stays 1 and pix_valid stays 1; the sequence then resumes unchanged.
REQ-035 Second request valid during the last pixel -> accepted on that edge; rom_ce one cycle later; no pix_valid for exactly 2 cycles.
REQ-036 resetn pulsed low after 2 pixels of a glyph -> outputs at reset values within the same cycle; no further pixels after release.
REQ-037 GLYPH_INVERT_EN defined, req_inv 1, rom_dout 5'b11000 -> pix sequence 0,0,1,1,1,1.

Source files
------------

// File: rtl/glyph_serializer.sv
//------------------------------------------------------------------------------
// glyph_serializer
//
// Purpose:
//   Turns a character request (code + scan line) into a serial stream of
//   pixels for one scan line of a 5-pixel-wide glyph, followed by GAP_BITS
//   blank columns. The glyph bitmap is read from an external synchronous ROM
//   laid out as 7 scan lines per character (address = code*7 + row).
//   Scan line 7 is treated as an all-blank spacer line and never touches
//   the ROM.
//
// Parameters:
//   GAP_BITS   blank columns appended after the 5 glyph pixels (0..3)
//
// Optional feature:
//   GLYPH_INVERT_EN  when defined, adds the req_inv port; a request latched
//                    with req_inv = 1 has every output pixel (glyph and gap)
//                    inverted.
//
// Ports:
//   clk        in   1   clock, all state changes on rising edge
//   resetn     in   1   asynchronous active-low reset
//   req_valid  in   1   character request present
//   req_ready  out  1   request accepted this cycle
//   req_code   in   8   character code
//   req_row    in   3   scan line 0..6 (7 = blank line)
//   req_inv    in   1   reverse-video attribute (GLYPH_INVERT_EN only)
//   rom_ad     out  11  glyph ROM address (held while rom_ce = 0)
//   rom_ce     out  1   glyph ROM read enable
//   rom_dout   in   5   ROM data, valid the cycle after rom_ce
//   pix        out  1   current pixel, 1 = foreground
//   pix_valid  out  1   pix holds a valid pixel
//   pix_ready  in   1   consumer takes pix this cycle
//------------------------------------------------------------------------------
module glyph_serializer #(
   parameter int GAP_BITS = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_code,
   input  logic [2:0]  req_row,
`ifdef GLYPH_INVERT_EN
   input  logic        req_inv,
`endif
   output logic [10:0] rom_ad,
   output logic        rom_ce,
   input  logic [4:0]  rom_dout,
   output logic        pix,
   output logic        pix_valid,
   input  logic        pix_ready
);

   localparam int SR_W = 5 + GAP_BITS;

   // Index of the final column of a scan line (glyph + gap)
   localparam logic [3:0] LAST_IDX = 4'(SR_W - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_SHIFT = 2'd3;

   localparam logic [2:0] BLANK_ROW = 3'd7;

   // Glyph ROM address: 7 scan lines per character, max 255*7+6 = 1791
   function automatic logic [10:0] f_glyph_addr(input logic [7:0] code,
                                                input logic [2:0] row);
      logic [10:0] v_code;
      v_code = {3'b000, code};
      return (v_code << 3) - v_code + {8'h00, row};
   endfunction

   logic [1:0]      r_state;
   logic [7:0]      r_code;
   logic [2:0]      r_row;
   logic [10:0]     r_ad_hold;
   logic [SR_W-1:0] r_sr;
   logic [3:0]      r_cnt;

   logic            w_req_fire;
   logic            w_pix_fire;
   logic            w_last;
   logic            w_inv;
   logic [10:0]     w_glyph_ad;
   logic [SR_W-1:0] w_load;

`ifdef GLYPH_INVERT_EN
   logic            r_inv;
   assign w_inv = r_inv;
`else
   assign w_inv = 1'b0;
`endif

   assign w_glyph_ad = f_glyph_addr(r_code, r_row);

   // ROM line placed in the top five bits, gap columns (if any) stay zero
   always_comb begin
      w_load                = '0;
      w_load[SR_W-1 -: 5]   = rom_dout;
   end

   //---------------------------------------------------------------------------
   // Handshake decode
   //---------------------------------------------------------------------------
   assign pix_valid  = (r_state == S_SHIFT);
   assign w_pix_fire = pix_valid && pix_ready;
   assign w_last     = (r_state == S_SHIFT) && (r_cnt == LAST_IDX);

   // A new request can only overlap the transfer of the final column, so
   // req_ready depends combinationally on pix_ready in that one cycle.
   assign req_ready  = (r_state == S_IDLE) || (w_last && pix_ready);
   assign w_req_fire = req_valid && req_ready;

   //---------------------------------------------------------------------------
   // ROM interface: address is only driven live during FETCH; otherwise the
   // last fetched address is replayed so rom_ad never wanders while idle.
   //---------------------------------------------------------------------------
   assign rom_ce = (r_state == S_FETCH);
   assign rom_ad = rom_ce ? w_glyph_ad : r_ad_hold;

   // Gated with pix_valid so an inverted request never leaks a 1 while idle
   assign pix = pix_valid && (r_sr[SR_W-1] ^ w_inv);

   //---------------------------------------------------------------------------
   // Control FSM and datapath
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_code    <= '0;
         r_row     <= '0;
         r_ad_hold <= '0;
         r_sr      <= '0;
         r_cnt     <= '0;
`ifdef GLYPH_INVERT_EN
         r_inv     <= 1'b0;
`endif
      end else if (w_req_fire) begin
         // Accept a request from IDLE or on the last column of a glyph
         r_code <= req_code;
         r_row  <= req_row;
`ifdef GLYPH_INVERT_EN
         r_inv  <= req_inv;
`endif
         r_cnt  <= '0;
         if (req_row == BLANK_ROW) begin
            r_sr    <= '0;
            r_state <= S_SHIFT;
         end else begin
            r_state <= S_FETCH;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_IDLE;
            end
            S_FETCH: begin
               r_ad_hold <= w_glyph_ad;
               r_state   <= S_LOAD;
            end
            S_LOAD: begin
               r_sr    <= w_load;
               r_cnt   <= '0;
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               if (w_pix_fire) begin
                  r_sr <= {r_sr[SR_W-2:0], 1'b0};
                  if (w_last) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_glyph_serializer.sv
//------------------------------------------------------------------------------
// tb_glyph_serializer
//
// Directed bench for glyph_serializer with GAP_BITS = 1. A small synchronous
// ROM model returns rom_val one cycle after each rom_ce and counts reads.
// Inputs change right after the falling edge; outputs are sampled there too.
//------------------------------------------------------------------------------
module tb_glyph_serializer;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_code;
   logic [2:0]  req_row;
`ifdef GLYPH_INVERT_EN
   logic        req_inv;
`endif
   logic [10:0] rom_ad;
   logic        rom_ce;
   logic [4:0]  rom_dout;
   logic        pix;
   logic        pix_valid;
   logic        pix_ready;

   logic [4:0]  rom_val;
   int          ce_count;
   int          errors;
   int          checks;

   glyph_serializer #(.GAP_BITS(1)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_code  (req_code),
      .req_row   (req_row),
`ifdef GLYPH_INVERT_EN
      .req_inv   (req_inv),
`endif
      .rom_ad    (rom_ad),
      .rom_ce    (rom_ce),
      .rom_dout  (rom_dout),
      .pix       (pix),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered ROM: data appears the cycle after rom_ce
   initial begin
      rom_dout = 5'd0;
      ce_count = 0;
   end
   always @(posedge clk) begin
      if (rom_ce) begin
         rom_dout <= rom_val;
         ce_count <= ce_count + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
      end
      checks++;
      if (rom_ce !== 1'b0) begin
         errors++; $display("FAIL reset_rom_ce: got %b want 0", rom_ce);
      end
      checks++;
      if (rom_ad !== 11'd0) begin
         errors++; $display("FAIL reset_rom_ad: got %0d want 0", rom_ad);
      end
      checks++;
      if (pix_valid !== 1'b0 || pix !== 1'b0) begin
         errors++; $display("FAIL reset_pix: got pv=%b pix=%b want 0 0", pix_valid, pix);
      end
      resetn = 1'b1;
   endtask

   // REQ: code 0x41 row 2, ROM 10101 -> address 457, pixels 1,0,1,0,1,0
   task automatic test_basic();
      logic [5:0] e;
      int         base;
      e    = 6'b101010;
      base = ce_count;
      rom_val   = 5'b10101;
      pix_ready = 1'b1;
      req_valid = 1'b1;
      req_code  = 8'h41;
      req_row   = 3'd2;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL basic_ready_idle: got %b want 1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (rom_ce !== 1'b1 || rom_ad !== 11'd457 || pix_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_fetch: got ce=%b ad=%0d pv=%b want 1 457 0", rom_ce, rom_ad, pix_valid);
      end
      @(negedge clk);
      checks++;
      if (rom_ce !== 1'b0 || rom_ad !== 11'd457 || pix_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_load: got ce=%b ad=%0d pv=%b want 0 457 0", rom_ce, rom_ad, pix_valid);
      end
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (pix_valid !== 1'b1 || pix !== e[5-i] || req_ready !== (i == 5)) begin
            errors++;
            $display("FAIL basic_pix%0d: got pv=%b pix=%b rdy=%b want 1 %b %b",
                     i, pix_valid, pix, req_ready, e[5-i], (i == 5));
         end
         @(negedge clk);
      end
      checks++;
      if (pix_valid !== 1'b0 || req_ready !== 1'b1 || (ce_count - base) != 1) begin
         errors++;
         $display("FAIL basic_end: got pv=%b rdy=%b reads=%0d want 0 1 1",
                  pix_valid, req_ready, ce_count - base);
      end
   endtask

   // Row 7 -> no ROM read, six blank pixels starting the very next cycle
   task automatic test_row7();
      int base;
      base = ce_count;
      rom_val   = 5'b11111;
      pix_ready = 1'b1;
      req_valid = 1'b1;
      req_code  = 8'hFF;
      req_row   = 3'd7;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (pix_valid !== 1'b1 || pix !== 1'b0 || rom_ce !== 1'b0) begin
            errors++;
            $display("FAIL row7_pix%0d: got pv=%b pix=%b ce=%b want 1 0 0", i, pix_valid, pix, rom_ce);
         end
         @(negedge clk);
      end
      checks++;
      if (pix_valid !== 1'b0 || (ce_count - base) != 0 || rom_ad !== 11'd457) begin
         errors++;
         $display("FAIL row7_end: got pv=%b reads=%0d ad=%0d want 0 0 457",
                  pix_valid, ce_count - base, rom_ad);
      end
   endtask

   // Consumer stalls 4 cycles on the first pixel; sequence resumes intact
   task automatic test_stall();
      logic [5:0] e;
      e = 6'b100110;
      rom_val   = 5'b10011;
      pix_ready = 1'b1;
      req_valid = 1'b1;
      req_code  = 8'h10;
      req_row   = 3'd0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      pix_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (pix_valid !== 1'b1 || pix !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: got pv=%b pix=%b rdy=%b want 1 1 0", k, pix_valid, pix, req_ready);
         end
         @(negedge clk);
      end
      pix_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (pix_valid !== 1'b1 || pix !== e[5-i]) begin
            errors++;
            $display("FAIL stall_pix%0d: got pv=%b pix=%b want 1 %b", i, pix_valid, pix, e[5-i]);
         end
         @(negedge clk);
      end
      checks++;
      if (pix_valid !== 1'b0) begin
         errors++; $display("FAIL stall_end: got pv=%b want 0", pix_valid);
      end
   endtask

   // Second request accepted on the last pixel; exactly two dead cycles
   task automatic test_back_to_back();
      logic [5:0] ea;
      logic [5:0] eb;
      int         base;
      ea   = 6'b111110;
      eb   = 6'b011100;
      base = ce_count;
      rom_val   = 5'b11111;
      pix_ready = 1'b1;
      req_valid = 1'b1;
      req_code  = 8'h01;
      req_row   = 3'd6;
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (rom_ad !== 11'd13) begin
         errors++; $display("FAIL b2b_addr_a: got %0d want 13", rom_ad);
      end
      @(negedge clk);
      @(negedge clk);
      rom_val = 5'b01110;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            req_valid = 1'b1;
            req_code  = 8'h02;
            req_row   = 3'd3;
         end
         checks++;
         if (pix_valid !== 1'b1 || pix !== ea[5-i] || req_ready !== (i == 5)) begin
            errors++;
            $display("FAIL b2b_a_pix%0d: got pv=%b pix=%b rdy=%b want 1 %b %b",
                     i, pix_valid, pix, req_ready, ea[5-i], (i == 5));
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      checks++;
      if (rom_ce !== 1'b1 || rom_ad !== 11'd17 || pix_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_fetch: got ce=%b ad=%0d pv=%b want 1 17 0", rom_ce, rom_ad, pix_valid);
      end
      @(negedge clk);
      checks++;
      if (rom_ce !== 1'b0 || pix_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_load: got ce=%b pv=%b want 0 0", rom_ce, pix_valid);
      end
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (pix_valid !== 1'b1 || pix !== eb[5-i]) begin
            errors++;
            $display("FAIL b2b_b_pix%0d: got pv=%b pix=%b want 1 %b", i, pix_valid, pix, eb[5-i]);
         end
         @(negedge clk);
      end
      checks++;
      if (pix_valid !== 1'b0 || (ce_count - base) != 2) begin
         errors++;
         $display("FAIL b2b_end: got pv=%b reads=%0d want 0 2", pix_valid, ce_count - base);
      end
   endtask

   // Reset after two pixels: immediate return to reset values, nothing after
   task automatic test_reset_mid();
      rom_val   = 5'b11111;
      pix_ready = 1'b1;
      req_valid = 1'b1;
      req_code  = 8'h55;
      req_row   = 3'd4;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (pix_valid !== 1'b1 || pix !== 1'b1) begin
         errors++; $display("FAIL rstmid_before: got pv=%b pix=%b want 1 1", pix_valid, pix);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if (pix_valid !== 1'b0 || pix !== 1'b0 || rom_ce !== 1'b0 ||
          rom_ad !== 11'd0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_async: got pv=%b pix=%b ce=%b ad=%0d rdy=%b want 0 0 0 0 1",
                  pix_valid, pix, rom_ce, rom_ad, req_ready);
      end
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (pix_valid !== 1'b0 || rom_ce !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after%0d: got pv=%b ce=%b want 0 0", k, pix_valid, rom_ce);
         end
      end
   endtask

`ifdef GLYPH_INVERT_EN
   // Inverted request: ROM 11000 with gap -> 0,0,1,1,1,1
   task automatic test_invert();
      logic [5:0] e;
      e = 6'b001111;
      rom_val   = 5'b11000;
      pix_ready = 1'b1;
      req_valid = 1'b1;
      req_inv   = 1'b1;
      req_code  = 8'h20;
      req_row   = 3'd1;
      @(negedge clk);
      req_valid = 1'b0;
      req_inv   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (pix_valid !== 1'b1 || pix !== e[5-i]) begin
            errors++;
            $display("FAIL inv_pix%0d: got pv=%b pix=%b want 1 %b", i, pix_valid, pix, e[5-i]);
         end
         @(negedge clk);
      end
      checks++;
      if (pix_valid !== 1'b0 || pix !== 1'b0) begin
         errors++; $display("FAIL inv_end: got pv=%b pix=%b want 0 0", pix_valid, pix);
      end
   endtask
`endif

   initial begin
      errors    = 0;
      checks    = 0;
      resetn    = 1'b0;
      req_valid = 1'b0;
      req_code  = 8'h00;
      req_row   = 3'd0;
      pix_ready = 1'b0;
      rom_val   = 5'd0;
`ifdef GLYPH_INVERT_EN
      req_inv   = 1'b0;
`endif
      test_reset();
      test_basic();
      test_row7();
      test_stall();
      test_back_to_back();
      test_reset_mid();
`ifdef GLYPH_INVERT_EN
      test_invert();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
